// File: rtl/systolic_result_collector_if.sv
// Stream bundle between the systolic array, the result collector and the element consumer.
// The master side feeds rows and accepts elements; the slave side is the collector.
interface systolic_result_collector_if #(
    parameter int N_SIZE    = 5,
    parameter int DATAWIDTH = 16,
    parameter int OUTWIDTH  = 32
);
    localparam int IW = 2 * DATAWIDTH;
    localparam int CW = $clog2(N_SIZE);

    logic                       valid_in;
    logic [N_SIZE-1:0][IW-1:0]  matrix_c_in;
    logic                       in_ready;

    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUTWIDTH-1:0] out_data;
    logic [CW-1:0]              out_row;
    logic [CW-1:0]              out_col;
    logic                       out_last;
    logic                       out_sat;

    logic                       overflow;
    logic                       clear_ovf;

    modport master (
        output valid_in, matrix_c_in, out_ready, clear_ovf,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last, out_sat, overflow
    );

    modport slave (
        input  valid_in, matrix_c_in, out_ready, clear_ovf,
        output in_ready, out_valid, out_data, out_row, out_col, out_last, out_sat, overflow
    );
endinterface

// File: rtl/systolic_result_collector.sv
// Ping-pong capture of systolic-array result rows and row-major element drain with optional saturation.
// A whole matrix is accepted or discarded at its first row; discards raise a sticky overflow flag.
module systolic_result_collector #(
    parameter int N_SIZE    = 5,
    parameter int DATAWIDTH = 16,
    parameter int OUTWIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    systolic_result_collector_if.slave  io_bus
);
    localparam int IW    = 2 * DATAWIDTH;
    localparam int CW    = $clog2(N_SIZE);
    localparam int DEPTH = 2 * N_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SIZE - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    // write side
    logic [CW-1:0]       r_wr_row;
    logic                r_wr_bank;
    logic                r_accept;
    logic [1:0]          r_full;
    logic                w_row0;
    logic                w_accept;
    logic                w_wr_en;
    logic                w_wr_done;
    logic                w_discard;
    logic [1:0]          w_full_set;
    logic [1:0]          w_full_clr;
    logic [AW-1:0]       w_wr_addr;

    // read side
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                r_rd_bank;
    logic                w_other_bank;
    logic                w_xfer;
    logic                w_drain_done;
    logic                w_load;
    logic                w_ld_bank;
    logic [CW-1:0]       w_ld_row;
    logic [CW-1:0]       w_ld_col;
    logic                w_ld_last;
    logic [AW-1:0]       w_rd_addr;
    logic [IW-1:0]       w_col_data [N_SIZE];
    logic [IW-1:0]       w_elem;
    logic [OUTWIDTH-1:0] w_sat_data;
    logic                w_sat_flag;

    // output register
    logic [OUTWIDTH-1:0] r_out_data;
    logic [CW-1:0]       r_out_row;
    logic [CW-1:0]       r_out_col;
    logic                r_out_last;
    logic                r_out_sat;
    logic                r_overflow;

    // Accept/discard is latched at row 0 and reused for the remaining rows of the matrix.
    assign w_row0     = (r_wr_row == '0);
    assign w_accept   = w_row0 ? !r_full[r_wr_bank] : r_accept;
    assign w_wr_en    = io_bus.valid_in && w_accept;
    assign w_wr_done  = w_wr_en && (r_wr_row == LAST_IDX);
    assign w_discard  = io_bus.valid_in && w_row0 && r_full[r_wr_bank];
    assign w_full_set = w_wr_done    ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_drain_done ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_wr_addr  = AW'(N_SIZE * int'(r_wr_bank) + int'(r_wr_row));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_row   <= '0;
            r_wr_bank  <= 1'b0;
            r_accept   <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            if (io_bus.valid_in) begin
                r_wr_row <= (r_wr_row == LAST_IDX) ? '0 : r_wr_row + 1'b1;
                if (w_row0) begin
                    r_accept <= w_accept;
                end
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_discard) begin
                r_overflow <= 1'b1;
            end else if (io_bus.clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // One RAM per column: a full row is written in one cycle, one element is read per cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_SIZE; gi++) begin : g_col
            logic [IW-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    r_mem[w_wr_addr] <= io_bus.matrix_c_in[gi];
                end
            end

            assign w_col_data[gi] = r_mem[w_rd_addr];
        end
    endgenerate

    assign w_xfer       = (r_state == S_DRAIN) && io_bus.out_ready;
    assign w_other_bank = ~r_rd_bank;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drain_done = 1'b0;
        w_ld_bank    = r_rd_bank;
        w_ld_row     = '0;
        w_ld_col     = '0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_load       = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    if (r_out_last) begin
                        // Hand over straight to the other bank when it is already waiting.
                        w_drain_done = 1'b1;
                        w_ld_bank    = w_other_bank;
                        if (r_full[w_other_bank]) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_load = 1'b1;
                        if (r_out_col == LAST_IDX) begin
                            w_ld_row = r_out_row + 1'b1;
                            w_ld_col = '0;
                        end else begin
                            w_ld_row = r_out_row;
                            w_ld_col = r_out_col + 1'b1;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_ld_last = (w_ld_row == LAST_IDX) && (w_ld_col == LAST_IDX);
    assign w_rd_addr = AW'(N_SIZE * int'(w_ld_bank) + int'(w_ld_row));
    assign w_elem    = w_col_data[w_ld_col];

    generate
        if (OUTWIDTH < IW) begin : g_sat
            localparam logic [OUTWIDTH-1:0] OUT_MIN = OUTWIDTH'(1) << (OUTWIDTH - 1);
            localparam logic [OUTWIDTH-1:0] OUT_MAX = ~OUT_MIN;
            logic [IW-OUTWIDTH:0] w_upper;

            // The value fits when every bit from the output sign bit upward agrees.
            assign w_upper    = w_elem[IW-1:OUTWIDTH-1];
            assign w_sat_flag = !((&w_upper) || !(|w_upper));
            assign w_sat_data = !w_sat_flag ? w_elem[OUTWIDTH-1:0]
                                            : (w_elem[IW-1] ? OUT_MIN : OUT_MAX);
        end else begin : g_pass
            assign w_sat_data = w_elem[OUTWIDTH-1:0];
            assign w_sat_flag = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_bank  <= 1'b0;
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_out_last <= 1'b0;
            r_out_sat  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_drain_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_load) begin
                r_out_data <= w_sat_data;
                r_out_row  <= w_ld_row;
                r_out_col  <= w_ld_col;
                r_out_last <= w_ld_last;
                r_out_sat  <= w_sat_flag;
            end
        end
    end

    assign io_bus.in_ready  = !r_full[r_wr_bank];
    assign io_bus.out_valid = (r_state == S_DRAIN);
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_row   = r_out_row;
    assign io_bus.out_col   = r_out_col;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.out_sat   = r_out_sat;
    assign io_bus.overflow  = r_overflow;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Drives a full-width and a 16-bit saturating collector with the same row stream and
// checks both against a matrix-FIFO model every cycle, plus hand-computed beat sequences.
module tb_systolic_result_collector;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   tb_valid_in  = 1'b0;
    logic                   tb_out_ready = 1'b0;
    logic                   tb_clear_ovf = 1'b0;
    logic [N-1:0][2*DW-1:0] tb_row       = '0;
    bit                     bp_mode      = 1'b0;

    systolic_result_collector_if #(.N_SIZE(N), .DATAWIDTH(DW), .OUTWIDTH(32)) bus32 ();
    systolic_result_collector_if #(.N_SIZE(N), .DATAWIDTH(DW), .OUTWIDTH(16)) bus16 ();

    assign bus32.valid_in    = tb_valid_in;
    assign bus32.matrix_c_in = tb_row;
    assign bus32.out_ready   = tb_out_ready;
    assign bus32.clear_ovf   = tb_clear_ovf;
    assign bus16.valid_in    = tb_valid_in;
    assign bus16.matrix_c_in = tb_row;
    assign bus16.out_ready   = tb_out_ready;
    assign bus16.clear_ovf   = tb_clear_ovf;

    systolic_result_collector #(.N_SIZE(N), .DATAWIDTH(DW), .OUTWIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .io_bus(bus32)
    );
    systolic_result_collector #(.N_SIZE(N), .DATAWIDTH(DW), .OUTWIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .io_bus(bus16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Model: a FIFO of at most two stored matrices, each visible to the reader from the
    // edge after its last row, drained one element per accepted beat.
    int     m_wr_row = 0;
    bit     m_accept = 1'b0;
    longint m_cur [NN];
    longint m_store [$];
    int     m_done [$];
    bit     m_valid = 1'b0;
    int     m_pos = 0;
    bit     m_ovf = 1'b0;
    int     m_edge = 0;

    always @(posedge clk or posedge rst) begin : model
        int  stored_before;
        bit  discard;
        if (rst) begin
            m_wr_row = 0;
            m_accept = 1'b0;
            m_store.delete();
            m_done.delete();
            m_valid  = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_edge++;
            stored_before = m_done.size();
            discard = 1'b0;
            if (m_valid && tb_out_ready) begin
                m_pos++;
                if (m_pos == NN) begin
                    for (int k = 0; k < NN; k++) void'(m_store.pop_front());
                    void'(m_done.pop_front());
                    m_pos   = 0;
                    m_valid = 1'b0;
                end
            end
            if (tb_valid_in) begin
                if (m_wr_row == 0) begin
                    m_accept = (stored_before < 2);
                    discard  = !m_accept;
                end
                if (m_accept) begin
                    for (int j = 0; j < N; j++) m_cur[m_wr_row*N + j] = longint'($signed(tb_row[j]));
                end
                if (m_wr_row == N - 1) begin
                    if (m_accept) begin
                        for (int k = 0; k < NN; k++) m_store.push_back(m_cur[k]);
                        m_done.push_back(m_edge);
                    end
                    m_wr_row = 0;
                end else begin
                    m_wr_row++;
                end
            end
            if (!m_valid && m_done.size() > 0 && m_done[0] < m_edge) begin
                m_valid = 1'b1;
                m_pos   = 0;
            end
            if (tb_clear_ovf) m_ovf = 1'b0;
            if (discard) m_ovf = 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        longint e;
        if (!rst) begin
            chk("valid32", bus32.out_valid, m_valid);
            chk("valid16", bus16.out_valid, m_valid);
            chk("in_ready32", bus32.in_ready, m_done.size() < 2);
            chk("in_ready16", bus16.in_ready, m_done.size() < 2);
            chk("overflow32", bus32.overflow, m_ovf);
            chk("overflow16", bus16.overflow, m_ovf);
            if (m_valid) begin
                e = m_store[m_pos];
                chk("data32", bus32.out_data, e);
                chk("sat32", bus32.out_sat, 1'b0);
                chk("data16", bus16.out_data, clamp16(e));
                chk("sat16", bus16.out_sat, clamp16(e) != e);
                chk("row", bus32.out_row, m_pos / N);
                chk("col", bus32.out_col, m_pos % N);
                chk("last", bus32.out_last, m_pos == NN - 1);
                chk("row16", bus16.out_row, m_pos / N);
                chk("last16", bus16.out_last, m_pos == NN - 1);
            end
        end
    end

    longint got32_q [$];
    longint got16_q [$];
    int     got_row_q [$];
    int     got_col_q [$];
    bit     got_last_q [$];
    bit     got_sat16_q [$];
    int     got_cyc_q [$];
    int     cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        if (!rst && bus32.out_valid && tb_out_ready) begin
            got32_q.push_back(longint'(bus32.out_data));
            got16_q.push_back(longint'(bus16.out_data));
            got_row_q.push_back(int'(bus32.out_row));
            got_col_q.push_back(int'(bus32.out_col));
            got_last_q.push_back(bus32.out_last);
            got_sat16_q.push_back(bus16.out_sat);
            got_cyc_q.push_back(cyc);
            $display("beat %0d (%0d,%0d) data32=%0d data16=%0d sat16=%0b last=%0b",
                     got32_q.size() - 1, bus32.out_row, bus32.out_col,
                     bus32.out_data, bus16.out_data, bus16.out_sat, bus32.out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) tb_out_ready = !tb_out_ready;
    endtask

    task automatic clear_got();
        got32_q.delete(); got16_q.delete(); got_row_q.delete(); got_col_q.delete();
        got_last_q.delete(); got_sat16_q.delete(); got_cyc_q.delete();
    endtask

    task automatic feed_rows(input int base, input bit clr0);
        for (int r = 0; r < N; r++) begin
            tick();
            tb_valid_in  = 1'b1;
            tb_clear_ovf = (r == 0) && clr0;
            for (int j = 0; j < N; j++) tb_row[j] = 32'(base + 10*r + j);
        end
    endtask

    task automatic end_feed();
        tick();
        tb_valid_in  = 1'b0;
        tb_clear_ovf = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int limit);
        int k = 0;
        while (got32_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        repeat (6) tick();
        chk("beat_count", got32_q.size(), n);
    endtask

    task automatic check_matrix(input int first, input int base);
        for (int k = 0; k < NN; k++) begin
            chk($sformatf("seq_data[%0d]", first + k), got32_q[first + k], base + 10*(k/N) + (k%N));
            chk($sformatf("seq_row[%0d]", first + k), got_row_q[first + k], k / N);
            chk($sformatf("seq_col[%0d]", first + k), got_col_q[first + k], k % N);
            chk($sformatf("seq_last[%0d]", first + k), got_last_q[first + k], k == NN - 1);
        end
    endtask

    int exp_sat_data [5] = '{32767, -32768, 32767, -32768, 0};
    bit exp_sat_flag [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin : stimulus
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", bus32.out_valid, 1'b0);
        chk("rst_in_ready", bus32.in_ready, 1'b1);
        chk("rst_overflow", bus32.overflow, 1'b0);

        // single matrix, consumer always ready
        tb_out_ready = 1'b1;
        feed_rows(0, 1'b0);
        end_feed();
        @(negedge clk);
        chk("lat_before", bus32.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid", bus32.out_valid, 1'b1);
        chk("lat_first", bus32.out_data, 0);
        wait_beats(NN, 100);
        check_matrix(0, 0);

        // backpressure: out_ready toggles every cycle
        clear_got();
        bp_mode = 1'b1;
        feed_rows(0, 1'b0);
        end_feed();
        wait_beats(NN, 200);
        bp_mode = 1'b0;
        tb_out_ready = 1'b0;
        check_matrix(0, 0);

        // ping-pong: three matrices back to back, third discarded (clear in same cycle as set)
        clear_got();
        repeat (3) tick();
        feed_rows(100, 1'b0);
        feed_rows(200, 1'b0);
        feed_rows(300, 1'b1);
        end_feed();
        @(negedge clk);
        chk("pp_overflow", bus32.overflow, 1'b1);
        chk("pp_in_ready", bus32.in_ready, 1'b0);
        chk("pp_head", bus32.out_data, 100);
        tick();
        tb_out_ready = 1'b1;
        wait_beats(2*NN, 150);
        check_matrix(0, 100);
        check_matrix(NN, 200);
        chk("pp_no_gap", got_cyc_q[2*NN-1] - got_cyc_q[0], 2*NN - 1);
        tb_clear_ovf = 1'b1;
        tick();
        tb_clear_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", bus32.overflow, 1'b0);
        chk("pp_in_ready_back", bus32.in_ready, 1'b1);

        // saturation on the 16-bit instance
        clear_got();
        for (int r = 0; r < N; r++) begin
            tick();
            tb_valid_in = 1'b1;
            tb_row[0] = 32'(40000);
            tb_row[1] = 32'(-40000);
            tb_row[2] = 32'(32767);
            tb_row[3] = 32'(-32768);
            tb_row[4] = 32'(0);
        end
        end_feed();
        wait_beats(NN, 100);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("sat_data[%0d]", j), got16_q[j], exp_sat_data[j]);
            chk($sformatf("sat_flag[%0d]", j), got_sat16_q[j], exp_sat_flag[j]);
        end
        chk("wide_keeps", got32_q[0], 40000);
        chk("wide_keeps_neg", got32_q[1], -40000);

        // asynchronous reset in the middle of a drain
        clear_got();
        feed_rows(0, 1'b0);
        end_feed();
        k = 0;
        while (got32_q.size() < 7 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("mid_transfers", got32_q.size(), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", bus32.out_valid, 1'b0);
        chk("arst_data", bus32.out_data, 0);
        chk("arst_row", bus32.out_row, 0);
        chk("arst_col", bus32.out_col, 0);
        chk("arst_last", bus32.out_last, 1'b0);
        chk("arst_sat", bus16.out_sat, 1'b0);
        chk("arst_data16", bus16.out_data, 0);
        chk("arst_in_ready", bus32.in_ready, 1'b1);
        chk("arst_overflow", bus32.overflow, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        clear_got();
        feed_rows(500, 1'b0);
        end_feed();
        wait_beats(NN, 100);
        check_matrix(0, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
